demux16_64: RTL and testbench

DEMUX16_64 -- requirements
Module: demux16_64

---
 rtl/demux16_64.sv | 109 ++++++++++
 tb/tb_demux16_64.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/demux16_64.sv
// demux16_64: routes DI into one of four registered outputs (A..D), manually via S
// or round-robin via PTR. Round-robin mode is compiled in only with DEMUX16_64_AUTO_EN.
module demux16_64 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] DI,
    input  logic             DI_VALID,
    input  logic [1:0]       S,
    input  logic             AUTO,
    input  logic             CLR,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [3:0]       VLD,
    output logic             FRAME,
    output logic [1:0]       PTR
);

    localparam logic [1:0] FILL0 = 2'd0;
    localparam logic [1:0] FILL1 = 2'd1;
    localparam logic [1:0] FILL2 = 2'd2;
    localparam logic [1:0] FILL3 = 2'd3;

    logic [1:0] dest;
    logic [3:0] dest_onehot;

`ifdef DEMUX16_64_AUTO_EN
    logic [1:0] state;
    logic [1:0] state_next;
    logic       frame_next;

    // Dropping AUTO forces FILL0 on the same edge, so a later rising AUTO starts at A.
    always_comb begin
        state_next = state;
        frame_next = 1'b0;
        dest       = S;
        if (!AUTO) begin
            state_next = FILL0;
        end else begin
            dest = state;
            if (DI_VALID) begin
                unique case (state)
                    FILL0:   state_next = FILL1;
                    FILL1:   state_next = FILL2;
                    FILL2:   state_next = FILL3;
                    FILL3:   state_next = FILL0;
                    default: state_next = FILL0;
                endcase
                frame_next = (state == FILL3);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL0;
            FRAME <= 1'b0;
        end else if (CLR) begin
            state <= FILL0;
            FRAME <= 1'b0;
        end else begin
            state <= state_next;
            FRAME <= frame_next;
        end
    end

    assign PTR = state;
`else
    logic unused_auto;

    assign unused_auto = AUTO;
    assign dest        = S;
    assign PTR         = FILL0;
    assign FRAME       = 1'b0;
`endif

    always_comb begin
        dest_onehot       = '0;
        dest_onehot[dest] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A   <= '0;
            B   <= '0;
            C   <= '0;
            D   <= '0;
            VLD <= '0;
        end else if (CLR) begin
            A   <= '0;
            B   <= '0;
            C   <= '0;
            D   <= '0;
            VLD <= '0;
        end else if (DI_VALID) begin
            VLD <= dest_onehot;
            if (dest_onehot[0]) A <= DI;
            if (dest_onehot[1]) B <= DI;
            if (dest_onehot[2]) C <= DI;
            if (dest_onehot[3]) D <= DI;
        end else begin
            VLD <= '0;
        end
    end

endmodule

// File: tb/tb_demux16_64.sv
// Self-checking bench for demux16_64: directed scenarios plus random traffic
// against a behavioural model; auto-mode expectations follow DEMUX16_64_AUTO_EN.
module tb_demux16_64;

`ifdef DEMUX16_64_AUTO_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] DI;
    logic        DI_VALID;
    logic [1:0]  S;
    logic        AUTO;
    logic        CLR;
    logic [15:0] A, B, C, D;
    logic [3:0]  VLD;
    logic        FRAME;
    logic [1:0]  PTR;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [15:0] m_out [4];
    logic [3:0]  m_vld;
    logic        m_frame;
    int          m_ptr;

    demux16_64 #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .DI(DI), .DI_VALID(DI_VALID), .S(S),
        .AUTO(AUTO), .CLR(CLR), .A(A), .B(B), .C(C), .D(D),
        .VLD(VLD), .FRAME(FRAME), .PTR(PTR)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".A"}, {16'h0, A}, {16'h0, m_out[0]});
        chk({tag, ".B"}, {16'h0, B}, {16'h0, m_out[1]});
        chk({tag, ".C"}, {16'h0, C}, {16'h0, m_out[2]});
        chk({tag, ".D"}, {16'h0, D}, {16'h0, m_out[3]});
        chk({tag, ".VLD"}, {28'h0, VLD}, {28'h0, m_vld});
        chk({tag, ".FRAME"}, {31'h0, FRAME}, {31'h0, m_frame});
        chk({tag, ".PTR"}, {30'h0, PTR}, m_ptr);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_out[i] = '0;
        m_vld   = '0;
        m_frame = 1'b0;
        m_ptr   = 0;
    endtask

    // One clock: apply inputs, advance the model by the documented rules, check after the edge.
    task automatic cycle(input logic [15:0] di, input logic v, input logic [1:0] s,
                         input logic au, input logic clr, input string tag);
        int  dst;
        bit  auto_on;
        DI = di; DI_VALID = v; S = s; AUTO = au; CLR = clr;
        auto_on = au && AUTO_EN;
        m_vld   = '0;
        m_frame = 1'b0;
        if (clr) begin
            model_reset();
        end else begin
            dst = auto_on ? m_ptr : int'(s);
            if (v) begin
                m_out[dst] = di;
                m_vld      = 4'(1 << dst);
                if (auto_on) begin
                    m_frame = (m_ptr == 3);
                    m_ptr   = (m_ptr + 1) % 4;
                end
            end
            if (!auto_on) m_ptr = 0;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n, input logic au, input string tag);
        for (int i = 0; i < n; i++)
            cycle(16'($urandom), 1'b0, 2'($urandom), au, 1'b0, tag);
    endtask

    initial begin
        logic [15:0] words [4];
        words[0] = 16'h0011; words[1] = 16'h0022; words[2] = 16'h0033; words[3] = 16'h0044;

        DI = '0; DI_VALID = 1'b0; S = '0; AUTO = 1'b0; CLR = 1'b0;
        rst = 1'b1;
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Manual writes on consecutive cycles; first edge after release captures.
        for (int i = 0; i < 4; i++)
            cycle(16'(i + 1), 1'b1, 2'(i), 1'b0, 1'b0, "manual");

        idle(5, 1'b0, "manual_idle");

        // Auto frame with idle gaps between words.
        for (int i = 0; i < 4; i++) begin
            cycle(words[i], 1'b1, 2'($urandom), 1'b1, 1'b0, "auto_frame");
            idle(int'($urandom_range(0, 3)), 1'b1, "auto_gap");
        end

        // Partial frame then AUTO falls, followed by a manual write to C.
        cycle(16'h0A01, 1'b1, 2'd3, 1'b1, 1'b0, "auto_part");
        cycle(16'h0A02, 1'b1, 2'd3, 1'b1, 1'b0, "auto_part");
        cycle(16'h0000, 1'b0, 2'd1, 1'b0, 1'b0, "auto_drop");
        cycle(16'h0C0C, 1'b1, 2'd2, 1'b0, 1'b0, "manual_after_drop");

        // Clear wins over a simultaneous capture.
        cycle(16'hBEEF, 1'b1, 2'd1, 1'b0, 1'b1, "clr_priority");
        cycle(16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, "post_clr");

        // Asynchronous reset mid-frame, between edges.
        cycle(16'h0B01, 1'b1, 2'd2, 1'b1, 1'b0, "pre_rst");
        cycle(16'h0B02, 1'b1, 2'd2, 1'b1, 1'b0, "pre_rst");
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        #1;
        rst = 1'b0;
        cycle(16'h0D0D, 1'b1, 2'd3, 1'b1, 1'b0, "after_rst_auto");

        // Random traffic, including mode switches and occasional clears.
        for (int i = 0; i < 300; i++)
            cycle(16'($urandom), 1'($urandom), 2'($urandom),
                  ($urandom_range(0, 7) != 0) ? AUTO : ~AUTO,
                  ($urandom_range(0, 31) == 0), "random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
